// File: rtl/sar_controller_if.sv
// Signal bundle between the SAR sequencer and its comparator/host side.
// master = the controller, slave = the comparator/host environment.
interface sar_if #(
   parameter int N = 12
);
   logic         start;
   logic         comp_result;
   logic         comp_done;
   logic         comp_req;
   logic         sample_en;
   logic         busy;
   logic         done;
   logic         err;
   logic [N-1:0] dac_code;
   logic [N-1:0] result;

   modport master (
      input  start, comp_result, comp_done,
      output comp_req, dac_code, sample_en, busy, done, result, err
   );

   modport slave (
      output start, comp_result, comp_done,
      input  comp_req, dac_code, sample_en, busy, done, result, err
   );
endinterface

// File: rtl/sar_controller.sv
// Successive-approximation sequencer: samples, then resolves one bit per SET/WAIT
// pair from MSB to LSB, with a per-bit comparator timeout that forces a 0.
//
//  state  | meaning
//  IDLE   | waiting for start, dac_code parked at 0
//  SAMPLE | track/hold closed for SAMPLE_CYCLES cycles
//  SET    | trial bit driven, comp_req strobe
//  WAIT   | waiting for comp_done or timeout, then decide bit
//  DONE   | result valid, done pulse
module sar_controller #(
   parameter int N             = 12,
   parameter int SAMPLE_CYCLES = 2,
   parameter int TIMEOUT       = 15
) (
   input  logic clk,
   input  logic rst,
   sar_if.master bus
);
   localparam int IW   = (N > 1) ? $clog2(N) : 1;
   localparam int CMAX = (SAMPLE_CYCLES > TIMEOUT) ? SAMPLE_CYCLES : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
   localparam logic [CW-1:0] SAMP_LD = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LD  = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      SET    = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  dac_q, dac_d;
   logic [N-1:0]  res_q, res_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          decide;
   logic          bit_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dac_q   <= '0;
         res_q   <= '0;
         idx_q   <= IDX_TOP;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dac_q   <= dac_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dac_d   = dac_q;
      res_d   = res_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      decide  = 1'b0;
      bit_v   = 1'b0;
      case (state_q)
         IDLE: begin
            dac_d = '0;
            if (bus.start) begin
               state_d = SAMPLE;
               err_d   = 1'b0;
               idx_d   = IDX_TOP;
               cnt_d   = SAMP_LD;
            end
         end
         SAMPLE: begin
            if (cnt_q == '0) begin
               state_d      = SET;
               dac_d[idx_q] = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SET: begin
            state_d = WAIT;
            cnt_d   = TMO_LD;
         end
         WAIT: begin
            if (bus.comp_done) begin
               decide = 1'b1;
               bit_v  = bus.comp_result;
            end else if (cnt_q == '0) begin
               // Comparator never answered: resolve the bit low and flag it.
               decide = 1'b1;
               err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
            if (decide) begin
               dac_d[idx_q] = bit_v;
               if (idx_q == '0) begin
                  state_d = DONE;
                  res_d   = dac_d;
               end else begin
                  idx_d        = idx_q - 1'b1;
                  dac_d[idx_d] = 1'b1;
                  state_d      = SET;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            dac_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.comp_req  = (state_q == SET);
   assign bus.sample_en = (state_q == SAMPLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.dac_code  = dac_q;
   assign bus.result    = res_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller: behavioural comparator plus a scoreboard of expected
// conversion results, error flag, latency and sample-phase length.
module tb_sar_controller;
   localparam int N  = 12;
   localparam int SC = 2;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sar_if #(.N(N)) bus ();

   sar_controller #(.N(N), .SAMPLE_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [N-1:0] res;
      logic         err;
      int           lat;
   } exp_t;

   exp_t          sbq[$];
   logic [N-1:0]  trials[$];
   int            total = 0;
   int            bad   = 0;
   int            done_cnt = 0;
   int            req_cnt  = 0;

   // comparator model controls
   logic [N-1:0]  vin = '0;
   int            dly = 0;
   bit            never = 0;
   bit            glitch = 0;
   bit            pend = 0;
   int            ccnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         pend = 0;
         bus.comp_done = 1'b0;
         bus.comp_result = 1'b0;
      end else if (bus.comp_req) begin
         req_cnt++;
         trials.push_back(bus.dac_code);
         pend = 1;
         ccnt = dly;
         if (glitch) begin
            bus.comp_done   = 1'b1;
            bus.comp_result = !(vin >= bus.dac_code);
         end else begin
            bus.comp_done = 1'b0;
         end
      end else if (pend && !never) begin
         if (ccnt == 0) begin
            bus.comp_done   = 1'b1;
            bus.comp_result = (vin >= bus.dac_code);
            pend = 0;
         end else begin
            ccnt--;
            bus.comp_done = 1'b0;
         end
      end else begin
         bus.comp_done = 1'b0;
      end
   end

   // scoreboard / monitor
   int  lat = 0;
   int  samp = 0;
   int  idle_run = 0;
   int  last_gap = 0;
   bit  busy_prev = 0;
   exp_t e;

   always @(negedge clk) begin
      if (bus.busy && !busy_prev) begin
         lat = 1;
         samp = bus.sample_en ? 1 : 0;
         last_gap = idle_run;
      end else if (bus.busy) begin
         lat++;
         samp += bus.sample_en ? 1 : 0;
      end
      idle_run = bus.busy ? 0 : idle_run + 1;
      busy_prev = bus.busy;
      if (bus.done) begin
         done_cnt++;
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: result=%h with no conversion pending", bus.result);
         end else begin
            e = sbq.pop_front();
            if (bus.result !== e.res || bus.err !== e.err || lat != e.lat || samp != SC) begin
               bad++;
               $display("FAIL conversion: got result=%h err=%b lat=%0d samp=%0d, want result=%h err=%b lat=%0d samp=%0d",
                        bus.result, bus.err, lat, samp, e.res, e.err, e.lat, SC);
            end
         end
      end
   end

   function automatic int exp_lat(input int d, input bit nev);
      int w;
      w = nev ? TO : d + 1;
      return SC + N * (1 + w) + 1;
   endfunction

   task automatic do_conv(input logic [N-1:0] v, input int d, input bit nev, input bit gl, input string name);
      exp_t x;
      int   n0;
      bit   seen;
      vin = v; dly = d; never = nev; glitch = gl;
      x.res = nev ? '0 : v;
      x.err = nev;
      x.lat = exp_lat(d, nev);
      sbq.push_back(x);
      n0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.sample_en !== 1'b1) begin
         bad++;
         $display("FAIL %s_accept: busy=%b err=%b sample_en=%b, want 1 0 1", name, bus.busy, bus.err, bus.sample_en);
      end
      seen = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (done_cnt > n0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: no done within 400 cycles", name);
      end
      @(negedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.dac_code !== '0) begin
         bad++;
         $display("FAIL %s_idle: busy=%b dac_code=%h, want 0 000", name, bus.busy, bus.dac_code);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.comp_req, bus.sample_en, bus.busy, bus.done, bus.err, bus.dac_code, bus.result} !== '0) begin
         bad++;
         $display("FAIL reset_values: req=%b samp=%b busy=%b done=%b err=%b dac=%h res=%h, want all 0",
                  bus.comp_req, bus.sample_en, bus.busy, bus.done, bus.err, bus.dac_code, bus.result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [N-1:0] want[3];
      want[0] = 12'h800; want[1] = 12'hC00; want[2] = 12'hA00;
      trials.delete();
      do_conv(12'h800, 0, 0, 0, "mid");
      for (int i = 0; i < 3; i++) begin
         total++;
         if (trials.size() <= i || trials[i] !== want[i]) begin
            bad++;
            $display("FAIL trial_code_%0d: got %h, want %h", i, (trials.size() > i) ? trials[i] : 'x, want[i]);
         end
      end
      total++;
      if (trials.size() != N) begin
         bad++;
         $display("FAIL trial_count: got %0d, want %0d", trials.size(), N);
      end
   endtask

   task automatic test_codes();
      do_conv(12'hFFF, 0, 0, 0, "full");
      do_conv(12'h000, 0, 0, 0, "zero");
      do_conv(12'h5A3, 0, 0, 0, "5a3");
      for (int i = 0; i < 2; i++) do_conv(N'($urandom_range(0, 4095)), 0, 0, 0, "rand");
      do_conv(12'h3C5, 0, 0, 1, "set_glitch");
   endtask

   task automatic test_slow();
      do_conv(12'h9B7, 3, 0, 0, "slow");
   endtask

   task automatic test_timeout();
      do_conv(12'hABC, 0, 1, 0, "tmo");
      repeat (5) @(negedge clk);
      #1;
      total++;
      if (bus.err !== 1'b1 || bus.result !== '0) begin
         bad++;
         $display("FAIL err_sticky: err=%b result=%h, want 1 000", bus.err, bus.result);
      end
      do_conv(12'h123, 0, 0, 0, "after_tmo");
   endtask

   task automatic test_reset_mid();
      int  n0;
      int  r0;
      bit  hit;
      vin = 12'hABC; dly = 0; never = 0; glitch = 0;
      n0 = done_cnt;
      r0 = req_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      hit = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (req_cnt >= r0 + 6) begin
            hit = 1;
            break;
         end
      end
      total++;
      if (!hit || (bus.dac_code & 12'h07F) !== 12'h040) begin
         bad++;
         $display("FAIL bit6_reached: hit=%b dac=%h, want bit6 trial", hit, bus.dac_code);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({bus.comp_req, bus.sample_en, bus.busy, bus.done, bus.err, bus.dac_code} !== '0) begin
         bad++;
         $display("FAIL abort_reset: req=%b samp=%b busy=%b done=%b err=%b dac=%h, want all 0",
                  bus.comp_req, bus.sample_en, bus.busy, bus.done, bus.err, bus.dac_code);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      #1;
      total++;
      if (done_cnt != n0) begin
         bad++;
         $display("FAIL abort_no_done: done pulses=%0d, want 0", done_cnt - n0);
      end
      do_conv(12'h5A3, 0, 0, 0, "post_abort");
   endtask

   task automatic test_back_to_back();
      exp_t x;
      int   n0;
      bit   seen;
      vin = 12'h6D2; dly = 0; never = 0; glitch = 0;
      x.res = 12'h6D2; x.err = 1'b0; x.lat = exp_lat(0, 0);
      sbq.push_back(x);
      n0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         repeat (6) @(negedge clk);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      repeat (40) @(negedge clk);
      #1;
      total++;
      if (done_cnt != n0 + 1 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_ignored: done pulses=%0d busy=%b, want 1 0", done_cnt - n0, bus.busy);
      end
      vin = 12'h2E9;
      x.res = 12'h2E9;
      sbq.push_back(x);
      sbq.push_back(x);
      n0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      seen = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= n0 + 2) begin
            seen = 1;
            break;
         end
      end
      bus.start = 1'b0;
      total++;
      if (!seen || last_gap != 1) begin
         bad++;
         $display("FAIL held_start: done pulses=%0d idle gap=%0d, want 2 1", done_cnt - n0, last_gap);
      end
      repeat (5) @(negedge clk);
      #1;
      total++;
      if (done_cnt != n0 + 2 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL held_release: done pulses=%0d busy=%b, want 2 0", done_cnt - n0, bus.busy);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.comp_done = 1'b0;
      bus.comp_result = 1'b0;
      test_reset();
      test_basic();
      test_codes();
      test_slow();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d expected conversions never completed, want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
